// File: rtl/riscv_ctrl_pkg.sv
// Shared types and opcode constants for the multicycle RISC-V control path,
// the immediate generator and the datapath.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_ILLEGAL = 3'd4
    } iclass_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/ctrl_decoder.sv
// Opcode decoder: immediate format, ALU operand source, instruction class and
// illegal-opcode detection.
module ctrl_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output imm_sel_e   imm_sel_o,
    output logic       alu_src_o,
    output iclass_e    iclass_o,
    output logic       illegal_o
);

    always_comb begin
        imm_sel_o = IMM_I;
        alu_src_o = 1'b0;
        iclass_o  = CLS_ILLEGAL;
        case (opcode_i)
            OPC_OP: begin
                iclass_o = CLS_ALU;
            end
            OPC_OP_IMM: begin
                iclass_o  = CLS_ALU;
                alu_src_o = 1'b1;
            end
            OPC_LOAD: begin
                iclass_o  = CLS_LOAD;
                alu_src_o = 1'b1;
            end
            OPC_STORE: begin
                iclass_o  = CLS_STORE;
                imm_sel_o = IMM_S;
                alu_src_o = 1'b1;
            end
            OPC_BRANCH: begin
                iclass_o  = CLS_BRANCH;
                imm_sel_o = IMM_B;
            end
            default: begin
                iclass_o = CLS_ILLEGAL;
            end
        endcase
    end

    assign illegal_o = (iclass_o == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory
// timeout, sticky trap flags and a retired-instruction counter.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        mem_ack,
    input  logic        br_taken,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic        pc_sel,
    output logic [2:0]  imm_sel,
    output logic        alu_src,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        reg_wr,
    output logic        wb_sel,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instret
);

    localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [31:0]       instret_q, instret_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;

    imm_sel_e          dec_imm_sel;
    logic              dec_alu_src;
    iclass_e           dec_class;
    logic              dec_illegal;
    logic              unused_inst_bits;

    assign unused_inst_bits = ^inst[31:7];

    ctrl_decoder u_decoder (
        .opcode_i  (inst[6:0]),
        .imm_sel_o (dec_imm_sel),
        .alu_src_o (dec_alu_src),
        .iclass_o  (dec_class),
        .illegal_o (dec_illegal)
    );

    assign imm_sel = dec_imm_sel;
    assign alu_src = dec_alu_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            tmo_q     <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        ir_wr     = 1'b0;
        pc_wr     = 1'b0;
        pc_sel    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        reg_wr    = 1'b0;
        wb_sel    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                // An ack on the last waiting cycle still completes the fetch.
                if (mem_ack) begin
                    ir_wr   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (dec_class)
                    CLS_ALU: state_d = ST_WB;
                    CLS_LOAD, CLS_STORE: begin
                        tmo_d   = '0;
                        state_d = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        pc_wr   = 1'b1;
                        pc_sel  = br_taken;
                        tmo_d   = '0;
                        state_d = ST_FETCH;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_TRAP;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (dec_class == CLS_STORE);
                if (mem_ack) begin
                    tmo_d = '0;
                    if (dec_class == CLS_STORE) begin
                        pc_wr   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WB: begin
                reg_wr  = 1'b1;
                wb_sel  = (dec_class == CLS_LOAD);
                pc_wr   = 1'b1;
                tmo_d   = '0;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Reset sits in FETCH, so strobes are masked to keep an ack from leaking through.
        if (!rst_n) begin
            ir_wr  = 1'b0;
            pc_wr  = 1'b0;
            reg_wr = 1'b0;
        end

        instret_d = instret_q + {31'd0, pc_wr};
    end

    assign instret = instret_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: random instruction stream against a
// stage-count reference model, followed by trap and reset scenarios.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = 32'd0;
    logic        mem_ack = 1'b0;
    logic        br_taken = 1'b0;
    logic        ir_wr, pc_wr, pc_sel, alu_src, mem_req, mem_we, addr_sel;
    logic        reg_wr, wb_sel, illegal, bus_err;
    logic [2:0]  imm_sel;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inst     (inst),
        .mem_ack  (mem_ack),
        .br_taken (br_taken),
        .ir_wr    (ir_wr),
        .pc_wr    (pc_wr),
        .pc_sel   (pc_sel),
        .imm_sel  (imm_sel),
        .alu_src  (alu_src),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .addr_sel (addr_sel),
        .reg_wr   (reg_wr),
        .wb_sel   (wb_sel),
        .illegal  (illegal),
        .bus_err  (bus_err),
        .instret  (instret)
    );

    typedef struct {
        int          wf;
        logic        exp_pc_sel;
        int          exp_reg_wr;
        logic        exp_wb_sel;
        logic [2:0]  exp_imm;
        logic        exp_alu_src;
        logic        exp_mem_we;
        int          exp_lat;
        logic [31:0] exp_instret;
    } txn_t;

    txn_t        sbq[$];
    txn_t        cur;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    bit          have_cur = 1'b0;
    int          fcnt = 0;
    int          lat = 0;
    int          rw_cnt = 0;
    bit          we_seen = 1'b0;
    int          n_retired = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // kind: 0 = R-ALU, 1 = I-ALU, 2 = load, 3 = store, 4 = branch
    function automatic logic [6:0] opc(input int k);
        case (k)
            0:       return 7'b0110011;
            1:       return 7'b0010011;
            2:       return 7'b0000011;
            3:       return 7'b0100011;
            default: return 7'b1100011;
        endcase
    endfunction

    function automatic txn_t model(input int k, input int wf, input int wm, input logic br,
                                   input int retired);
        txn_t t;
        bit   uses_mem  = (k == 2) || (k == 3);
        bit   writes_rf = (k <= 2);
        t.wf          = wf;
        t.exp_pc_sel  = (k == 4) ? br : 1'b0;
        t.exp_reg_wr  = writes_rf ? 1 : 0;
        t.exp_wb_sel  = (k == 2);
        t.exp_imm     = (k == 3) ? 3'd1 : (k == 4) ? 3'd2 : 3'd0;
        t.exp_alu_src = (k == 1) || (k == 2) || (k == 3);
        t.exp_mem_we  = (k == 3);
        // cycles after the fetch-ack cycle: decode + exec, memory wait + ack, writeback
        t.exp_lat     = 2 + (uses_mem ? wm + 1 : 0) + (writes_rf ? 1 : 0);
        t.exp_instret = 32'(retired);
        return t;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_req && !addr_sel) begin
                if (ir_wr) begin
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_ir_wr: got 1 expected 0 at %0t", $time);
                    end else begin
                        cur = sbq.pop_front();
                        have_cur = 1'b1;
                        chk("fetch_wait", fcnt, cur.wf);
                        chk("instret_at_fetch", instret, cur.exp_instret);
                        lat = 0;
                        rw_cnt = 0;
                        we_seen = 1'b0;
                    end
                    fcnt = 0;
                end else begin
                    fcnt++;
                end
            end else if (have_cur) begin
                lat++;
                if (mem_we) we_seen = 1'b1;
                if (reg_wr) rw_cnt++;
                if (pc_wr) begin
                    chk("pc_sel", pc_sel, cur.exp_pc_sel);
                    chk("imm_sel", imm_sel, cur.exp_imm);
                    chk("alu_src", alu_src, cur.exp_alu_src);
                    chk("wb_sel", wb_sel, cur.exp_wb_sel);
                    chk("latency", lat, cur.exp_lat);
                    chk("mem_we_seen", we_seen, cur.exp_mem_we);
                    chk("reg_wr_count", rw_cnt, cur.exp_reg_wr);
                    have_cur = 1'b0;
                end
            end else if (pc_wr) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pc_wr: got 1 expected 0 at %0t", $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input int k, input int wf, input int wm, input logic br);
        logic [31:0] ins;
        int          guard;
        ins = $urandom;
        ins[6:0] = opc(k);
        br_taken = br;
        sbq.push_back(model(k, wf, wm, br, n_retired));
        n_retired++;
        repeat (wf) tick();
        inst = ins;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        if (k == 2 || k == 3) begin
            guard = 0;
            while (!(mem_req && addr_sel) && guard < 20) begin
                mem_ack = 1'($urandom_range(0, 1));
                tick();
                mem_ack = 1'b0;
                guard++;
            end
            if (guard >= 20) chk("wait_mem_timeout", 32'd1, 32'd0);
            repeat (wm) tick();
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        guard = 0;
        while (!(mem_req && !addr_sel) && guard < 20) begin
            mem_ack = 1'($urandom_range(0, 1));
            tick();
            mem_ack = 1'b0;
            guard++;
        end
        if (guard >= 20) chk("wait_fetch_timeout", 32'd1, 32'd0);
    endtask

    task automatic reset_check(input string nm);
        rst_n = 1'b0;
        #1;
        chk({nm, "_mem_req"}, mem_req, 1'b1);
        chk({nm, "_addr_sel"}, addr_sel, 1'b0);
        chk({nm, "_instret"}, instret, 32'd0);
        chk({nm, "_illegal"}, illegal, 1'b0);
        chk({nm, "_bus_err"}, bus_err, 1'b0);
    endtask

    task automatic lw_to_mem();
        inst = 32'h0000A183;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        reset_check("reset0");
        repeat (3) @(posedge clk);
        #1;
        fcnt = 0;
        mon_en = 1'b1;
        rst_n = 1'b1;

        for (int i = 0; i < 150; i++) begin
            run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end
        run_instr(2, 0, 3, 1'b0);
        run_instr(4, 0, 0, 1'b1);
        run_instr(4, 0, 0, 1'b0);
        repeat (2) tick();
        mon_en = 1'b0;
        chk("scoreboard_drained", sbq.size(), 0);
        chk("instret_total", instret, n_retired);

        // illegal opcode
        reset_check("reset_illegal");
        tick();
        rst_n = 1'b1;
        inst = 32'h0000007F;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("illegal_set", illegal, 1'b1);
        chk("illegal_no_buserr", bus_err, 1'b0);
        chk("trap_mem_req", mem_req, 1'b0);
        mem_ack = 1'b1;
        repeat (4) begin
            tick();
            chk("trap_strobes", {ir_wr, pc_wr, reg_wr, mem_req}, 4'b0000);
            chk("illegal_held", illegal, 1'b1);
        end
        mem_ack = 1'b0;

        // fetch timeout
        reset_check("reset_fetch_to");
        tick();
        rst_n = 1'b1;
        repeat (15) tick();
        chk("fetch_to_not_yet", bus_err, 1'b0);
        chk("fetch_to_still_req", mem_req, 1'b1);
        tick();
        chk("fetch_to_bus_err", bus_err, 1'b1);
        chk("fetch_to_trap", mem_req, 1'b0);
        mem_ack = 1'b1;
        repeat (3) tick();
        chk("bus_err_held", bus_err, 1'b1);
        chk("bus_err_no_ir_wr", ir_wr, 1'b0);
        mem_ack = 1'b0;

        // ack on the last allowed cycle wins over the timeout
        reset_check("reset_ack_wins");
        tick();
        rst_n = 1'b1;
        repeat (15) tick();
        inst = 32'h002081B3;
        mem_ack = 1'b1;
        #1;
        chk("ack_wins_ir_wr", ir_wr, 1'b1);
        tick();
        mem_ack = 1'b0;
        chk("ack_wins_no_buserr", bus_err, 1'b0);
        chk("ack_wins_decode", mem_req, 1'b0);
        tick();
        tick();
        chk("add_wb", {reg_wr, pc_wr, wb_sel}, 3'b110);
        tick();
        chk("add_instret", instret, 32'd1);
        chk("add_back_to_fetch", mem_req, 1'b1);

        // memory-phase timeout on a load
        lw_to_mem();
        chk("lw_mem_ctrl", {mem_req, addr_sel, mem_we, imm_sel, alu_src}, 7'b1100001);
        repeat (15) tick();
        chk("mem_to_not_yet", bus_err, 1'b0);
        tick();
        chk("mem_to_bus_err", bus_err, 1'b1);
        chk("mem_to_instret", instret, 32'd1);

        // reset in the middle of a load's memory phase
        reset_check("reset_mid");
        tick();
        rst_n = 1'b1;
        lw_to_mem();
        repeat (3) tick();
        chk("mid_in_mem", addr_sel, 1'b1);
        #2;
        rst_n = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("mid_async_fetch", {mem_req, addr_sel}, 2'b10);
        chk("mid_no_strobes", {ir_wr, pc_wr, reg_wr}, 3'b000);
        chk("mid_instret", instret, 32'd0);
        tick();
        chk("mid_held_no_strobes", {ir_wr, pc_wr, reg_wr}, 3'b000);
        mem_ack = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("mid_after_instret", instret, 32'd0);
        chk("mid_after_fetch", {mem_req, addr_sel}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max cycles a memory request waits for mem_ack before a bus error.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 inst  input  32  instruction register contents, stable from the cycle after ir_wr.
REQ-005 mem_ack  input  1  memory completion strobe, one cycle.
REQ-006 br_taken  input  1  branch comparator result, valid in EXEC.
REQ-007 ir_wr  output  1  load instruction register.
REQ-008 pc_wr  output  1  update PC; one pulse per retired instruction.
REQ-009 pc_sel  output  1  0 = PC+4, 1 = PC+imm.
REQ-010 imm_sel  output  3  immediate format for the immediate generator: I=0, S=1, B=2, U=3, J=4.
REQ-011 alu_src  output  1  0 = rs2, 1 = immediate.
REQ-012 mem_req / mem_we / addr_sel  output  1 each  memory request, write enable, address source (0 = PC, 1 = ALU).
REQ-013 reg_wr / wb_sel  output  1 each  register-file write, writeback source (0 = ALU, 1 = memory).
REQ-014 illegal / bus_err  output  1 each  sticky trap flags.
REQ-015 instret  output  32  retired-instruction counter.

Function
REQ-016 States SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP; state, timeout counter, instret and trap flags are registered; control outputs are combinational from state and inst[6:0].
REQ-017 FETCH: mem_req=1, addr_sel=0, mem_we=0; on mem_ack: ir_wr=1 in the same cycle, next DECODE; otherwise remain.
REQ-018 DECODE: opcode in {0110011, 0010011, 0000011, 0100011, 1100011} -> EXEC; any other opcode -> TRAP with illegal set on entry.
REQ-019 imm_sel SHALL be S for 0100011, B for 1100011, I otherwise (R-type drives I, don't-care); alu_src=1 for 0010011/0000011/0100011, else 0; held constant in DECODE/EXEC/MEM/WB.
REQ-020 EXEC: R/I-ALU -> WB; load/store -> MEM; branch -> pc_wr=1, pc_sel=br_taken, next FETCH.
REQ-021 MEM: mem_req=1, addr_sel=1, mem_we=1 only for store; on mem_ack: load -> WB; store -> pc_wr=1, pc_sel=0, next FETCH.
REQ-022 WB: reg_wr=1, wb_sel=1 for load else 0, pc_wr=1, pc_sel=0, next FETCH.
REQ-023 mem_req SHALL stay high until mem_ack; mem_ack in the same cycle as mem_req completes the access; mem_ack outside FETCH/MEM is ignored.
REQ-024 Timeout counter clears on entry to FETCH/MEM and on mem_ack; increments each waiting cycle; when count reaches MEM_TIMEOUT-1 without ack -> TRAP, bus_err set.
REQ-025 Latency with zero-wait memory: branch 3, R/I-ALU 4, store 4, load 5 cycles from FETCH entry to FETCH re-entry.
REQ-026 instret SHALL increment by 1 in every cycle pc_wr=1 and wrap 0xFFFFFFFF -> 0.
REQ-027 TRAP is terminal: all enables 0, illegal/bus_err held until reset.
REQ-028 mem_ack and timeout expiry in the same cycle: ack wins, no trap.

Reset
REQ-029 rst_n low SHALL asynchronously force state=FETCH, timeout counter=0, instret=0, illegal=0, bus_err=0; mem_req=1 immediately after deassertion.
REQ-030 Reset asserted mid-access SHALL abandon the access; no pc_wr, reg_wr or ir_wr occurs during reset.

Structure
REQ-031 Package riscv_ctrl_pkg SHALL hold the state enum, imm_sel enum (I/S/B/U/J) and opcode constants, shared with the immediate generator and datapath.
REQ-032 One sub-module, ctrl_decoder, SHALL map opcode to imm_sel, alu_src, instruction class and illegal.

Verification
REQ-033 add x3,x1,x2 (0x002081B3), mem_ack immediate -> DECODE, EXEC, WB; reg_wr=1 in WB; pc_wr once; instret 0->1.
REQ-034 lw (0x0000A183), MEM ack after 3 wait cycles -> imm_sel=I, addr_sel=1, wb_sel=1 in WB; 8 cycles total.
REQ-035 sw (0x0020A223) -> imm_sel=S, mem_we=1 only in MEM; no reg_wr; pc_sel=0.
REQ-036 beq (0x00208463) with br_taken=1 then =0 -> imm_sel=B, pc_sel 1 then 0; 3 cycles each; no reg_wr.
REQ-037 opcode 0x7F -> TRAP, illegal=1; separately, mem_ack withheld 16 cycles in FETCH -> bus_err=1; both held until rst_n low.
REQ-038 rst_n pulsed low during MEM of a load -> state FETCH asynchronously, no reg_wr, instret unchanged from 0 after reset.
